// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// legal WIDTH range.
package bit_serial_adder_pkg;

    // Controller states: waiting for operands, shifting bits, holding a result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Legal operand width range.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    // True when a requested width lies inside the supported range.
    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/bsa_fa_bit.sv
// One-bit full adder used by the bit-serial adder datapath.
module bsa_fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    // Sum and majority carry of the three input bits.
    always_comb begin
        s  = a ^ b ^ c;
        co = (a & b) | (a & c) | (b & c);
    end

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: accepts WIDTH-bit operands plus carry-in, adds one bit
// per clock LSB first, then holds S/CO/OV until the consumer takes them.
// Optional feature macro BIT_SERIAL_ADDER_SUB_EN adds a SUB input that turns
// the operation into A-B (B inverted, initial carry forced to 1).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. IN_READY is 1 only in IDLE, OUT_VALID is 1 only in HOLD; valid or
// ready seen in any other state is ignored.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
`ifdef BIT_SERIAL_ADDER_SUB_EN
    input  logic             SUB,
`endif
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OV,
    output state_t           dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] s_next;
    logic             sub_eff;

`ifdef BIT_SERIAL_ADDER_SUB_EN
    assign sub_eff = SUB;
`else
    assign sub_eff = 1'b0;
`endif

    // The new sum bit enters at the MSB so after WIDTH shifts bit 0 is at the LSB.
    assign s_next    = {fa_s, s_sh[WIDTH-1:1]};
    assign dbg_state = state;

    bsa_fa_bit u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .c  (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Controller and datapath: accept, shift one bit per cycle, hold result.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state     <= ST_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
            S         <= '0;
            CO        <= 1'b0;
            OV        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        a_sh     <= A;
                        b_sh     <= B ^ {WIDTH{sub_eff}};
                        carry    <= sub_eff ? 1'b1 : CI;
                        s_sh     <= '0;
                        cnt      <= '0;
                        S        <= '0;
                        CO       <= 1'b0;
                        OV       <= 1'b0;
                        IN_READY <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_next;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // carry currently holds the carry into the MSB.
                        S         <= s_next;
                        CO        <= fa_co;
                        OV        <= carry ^ fa_co;
                        OUT_VALID <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (OUT_READY) begin
                        S         <= '0;
                        CO        <= 1'b0;
                        OV        <= 1'b0;
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    OUT_VALID <= 1'b0;
                    IN_READY  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder at WIDTH=8: a table of hand-computed
// add vectors plus sequences for hold back-pressure, mid-run reset and
// operand changes during RUN.
module tb_bit_serial_adder;
    import bit_serial_adder_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    logic         CLK;
    logic         RSTB;
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CI;
    logic         SUB;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] S;
    logic         CO;
    logic         OV;
    state_t       dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vecs[$];

    bit_serial_adder #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RSTB      (RSTB),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .CI        (CI),
`ifdef BIT_SERIAL_ADDER_SUB_EN
        .SUB       (SUB),
`endif
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .S         (S),
        .CO        (CO),
        .OV        (OV),
        .dbg_state (dbg_state)
    );

    // Clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete operation. Entered and left at #1 after a rising edge in IDLE.
    // hold  : cycles OUT_READY stays low after OUT_VALID rises
    // noise : keep IN_VALID/OUT_READY high and change operands during RUN
    task automatic run_op(input vec_t v, input int hold, input bit noise);
        int lat;
        bit dirty;
        bit unstable;
        A         = v.a;
        B         = v.b;
        CI        = v.ci;
        SUB       = v.sub;
        IN_VALID  = 1'b1;
        OUT_READY = noise;
        check("in_ready_idle", IN_READY, 1);
        @(posedge CLK); #1;
        lat   = 0;
        dirty = 0;
        while (!OUT_VALID && lat < 3 * W) begin
            if (S !== '0 || CO !== 1'b0 || OV !== 1'b0 || IN_READY !== 1'b0 || dbg_state !== ST_RUN)
                dirty = 1;
            if (noise) begin
                A  = W'($urandom);
                B  = W'($urandom);
                CI = ~CI;
            end else begin
                IN_VALID = 1'b0;
            end
            @(posedge CLK); #1;
            lat++;
        end
        IN_VALID = 1'b0;
        check("latency", lat, W);
        check("run_clean", dirty, 0);
        check("sum", S, v.s);
        check("carry_out", CO, v.co);
        check("overflow", OV, v.ov);
        if (hold > 0) begin
            unstable = 0;
            for (int h = 0; h < hold; h++) begin
                @(posedge CLK); #1;
                if (S !== v.s || CO !== v.co || OV !== v.ov || OUT_VALID !== 1'b1 || IN_READY !== 1'b0)
                    unstable = 1;
            end
            check("hold_stable", unstable, 0);
        end
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        check("out_valid_drop", OUT_VALID, 0);
        check("in_ready_back", IN_READY, 1);
        check("sum_cleared", S, 0);
        check("state_idle", dbg_state, ST_IDLE);
    endtask

    initial begin
        vec_t v;
        bit   seen;

        // a, b, ci, sub, s, co, ov
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h3C, 8'h5A, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0});
        vecs.push_back('{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
`ifdef BIT_SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
        vecs.push_back('{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0});
`endif

        // Reset
        RSTB      = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        A         = '0;
        B         = '0;
        CI        = 1'b0;
        SUB       = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_in_ready", IN_READY, 1);
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_sum", S, 0);
        check("rst_co_ov", {CO, OV}, 0);
        check("rst_state", dbg_state, ST_IDLE);
        @(negedge CLK);
        RSTB = 1'b1;
        @(posedge CLK); #1;

        // Table vectors, OUT_READY taken immediately
        foreach (vecs[i]) run_op(vecs[i], 0, 1'b0);

        // Back-pressure: result held 5 cycles
        run_op(vecs[1], 5, 1'b0);

        // Operand changes and OUT_READY high during RUN
        run_op(vecs[0], 0, 1'b1);
        run_op(vecs[3], 0, 1'b1);

        // Reset after the third RUN edge aborts the operation
        A        = 8'h3C;
        B        = 8'h5A;
        CI       = 1'b1;
        SUB      = 1'b0;
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RSTB = 1'b0;
        #1;
        check("abort_in_ready", IN_READY, 1);
        check("abort_out_valid", OUT_VALID, 0);
        check("abort_sum", S, 0);
        @(negedge CLK);
        RSTB = 1'b1;
        seen = 0;
        for (int c = 0; c < 2 * W; c++) begin
            @(posedge CLK); #1;
            if (OUT_VALID !== 1'b0 || S !== '0 || IN_READY !== 1'b1) seen = 1;
        end
        check("abort_no_result", seen, 0);

        // Normal add after abort
        v = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};
        run_op(v, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RSTB, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port IN_VALID, input, 1 bit: operands A, B, CI are valid.
REQ-005 SHALL have port IN_READY, output, 1 bit: block can accept operands.
REQ-006 SHALL have port A, input, WIDTH bits: addend.
REQ-007 SHALL have port B, input, WIDTH bits: addend.
REQ-008 SHALL have port CI, input, 1 bit: carry-in.
REQ-009 SHALL have port OUT_VALID, output, 1 bit: S, CO and OV hold a completed result.
REQ-010 SHALL have port OUT_READY, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port S, output, WIDTH bits: sum.
REQ-012 SHALL have port CO, output, 1 bit: carry out of the MSB.
REQ-013 SHALL have port OV, output, 1 bit: signed overflow, equal to the carry into the MSB XOR CO.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, HOLD.
REQ-015 SHALL drive IN_READY=1 only in IDLE; SHALL drive OUT_VALID=1 only in HOLD.
REQ-016 SHALL accept operands when IN_VALID&&IN_READY at a rising edge: latch A, B and CI into shift/carry registers, clear S, clear the bit counter, IDLE->RUN.
REQ-017 In RUN, SHALL process exactly one bit per cycle, LSB first: sum bit = a^b^c, carry = ab|ac|bc; the sum bit is shifted into the S register MSB side and the carry is stored in the carry flop.
REQ-018 SHALL count bits with a counter of $clog2(WIDTH) bits; after the processing edge for bit WIDTH-1, SHALL go RUN->HOLD with CO = final carry and OV = carry into bit WIDTH-1 XOR CO.
REQ-019 Latency: OUT_VALID SHALL rise exactly WIDTH rising edges after the accept edge.
REQ-020 In HOLD, S, CO and OV SHALL stay stable until OUT_READY=1 at a rising edge; that edge SHALL go HOLD->IDLE. Zero-bubble back-to-back accept is not supported: a new accept occurs at the earliest one edge later.
REQ-021 IN_VALID outside IDLE SHALL be ignored with no state change; OUT_READY outside HOLD SHALL be ignored.
REQ-022 S, CO and OV SHALL read 0 while not in HOLD, with no partial result visible.

Reset
REQ-023 RSTB low SHALL immediately force IDLE, zero all data, carry and counter registers, and drive IN_READY=1, OUT_VALID=0, S=0, CO=0, OV=0.
REQ-024 Reset asserted mid-RUN or in HOLD SHALL abort the operation and discard it; no OUT_VALID pulse SHALL follow.
REQ-025 Reset deassertion SHALL be the only exit from reset; the first accept is possible at the first rising edge after deassertion.

Configuration
REQ-026 With macro BIT_SERIAL_ADDER_SUB_EN defined, SHALL add input port SUB (1 bit, sampled at accept); SUB=1 SHALL invert every B bit and force the initial carry to 1, ignoring CI, so the result is A-B; CO=1 means no borrow.
REQ-027 Without BIT_SERIAL_ADDER_SUB_EN, the SUB port SHALL not exist and the block SHALL perform add only.

Structure
REQ-028 A shared package bit_serial_adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/HOLD) and the WIDTH range constants.
REQ-029 The one-bit sum/carry logic SHALL be a sub-module bsa_fa_bit (inputs a, b, c; outputs s, co), instantiated once.

Verification
REQ-030 WIDTH=8, A=8'hFF, B=8'h01, CI=0, OUT_READY=1 -> after 8 edges S=8'h00, CO=1, OV=0, OUT_VALID for 1 cycle.
REQ-031 A=8'h3C, B=8'h5A, CI=1 -> S=8'h97, CO=0, OV=1.
REQ-032 OUT_READY held low 5 cycles after OUT_VALID rises -> S/CO/OV unchanged, IN_READY=0 throughout; OUT_READY=1 -> IDLE next edge.
REQ-033 RSTB pulsed low after the 3rd RUN edge -> OUT_VALID stays 0, S=0, IN_READY=1 after reset release; the next add completes correctly.
REQ-034 IN_VALID held high with new operands during RUN -> ignored; the result matches the first operand pair only.
REQ-035 With BIT_SERIAL_ADDER_SUB_EN, A=8'h05, B=8'h07, SUB=1 -> S=8'hFE, CO=0; A=8'h07, B=8'h05 -> S=8'h02, CO=1.
